// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment vector type, hex glyph table
// and the all-dark pattern. Bit order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_BLANK = 7'h00;

  // Glyphs for 0..9, A, b, c, d, E, F
  localparam seg7_t SEG7_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg7_t seg7_encode(input logic [3:0] nib);
    return SEG7_LUT[nib];
  endfunction

endpackage

// File: rtl/sevenseg_scan_if.sv
// Display bundle between the status/datapath side (master) and the
// scanning display driver (slave).
interface sevenseg_scan_if #(
  parameter int N_DIGITS = 4
);
  import seg7_pkg::*;

  localparam int IW = $clog2(N_DIGITS);

  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   blank;
  logic [N_DIGITS-1:0]   dp;
  logic [N_DIGITS-1:0]   blink_en;
  logic                  overlay_en;
  seg7_t                 seg;
  logic                  seg_dp;
  logic [N_DIGITS-1:0]   an;
  logic [IW-1:0]         scan_idx;
  logic                  frame_tick;

  modport master (
    output value, blank, dp, blink_en, overlay_en,
    input  seg, seg_dp, an, scan_idx, frame_tick
  );

  modport slave (
    input  value, blank, dp, blink_en, overlay_en,
    output seg, seg_dp, an, scan_idx, frame_tick
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment glyph decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg7_t      seg_o
);

  // Table lookup into the shared glyph set
  always_comb begin
    seg_o = seg7_encode(nib_i);
  end

endmodule

// File: rtl/sevenseg_scan.sv
// N-digit time-multiplexed seven-segment driver with internal scan
// prescaler, per-digit blank/dp/blink, anti-ghosting dead time and a
// constant overlay. All pin outputs are registered.
module sevenseg_scan
  import seg7_pkg::*;
#(
  parameter int                    N_DIGITS      = 4,
  parameter int                    SCAN_DIV      = 50000,
  parameter int                    DEAD          = 2,
  parameter int                    BLINK_LOG2    = 6,
  parameter int                    AN_ACTIVE_LOW = 1,
  parameter logic [4*N_DIGITS-1:0] OVERLAY       = 16'h0028
) (
  input logic           clk,
  input logic           rst,
  sevenseg_scan_if.slave disp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_ACTIVE_LOW != 0}};

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BLINK_LOG2-1:0] blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;

  seg7_t                 seg_q, seg_d;
  logic                  seg_dp_q, seg_dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  slot_tick;
  logic                  frame_wrap;
  logic [4*N_DIGITS-1:0] overlay_w;
  logic [3:0]            nib;
  seg7_t                 nib_seg;
  logic                  dark;
  logic [N_DIGITS-1:0]   onehot;

  assign overlay_w = OVERLAY;

  hex_to_seg7 u_dec (
    .nib_i (nib),
    .seg_o (nib_seg)
  );

  // Scan prescaler, digit index and blink phase next-state
  always_comb begin
    slot_tick     = (presc_q == PW'(SCAN_DIV - 1));
    frame_wrap    = slot_tick && (idx_q == IW'(N_DIGITS - 1));
    presc_d       = slot_tick ? '0 : presc_q + PW'(1);
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (slot_tick) begin
      idx_d       = frame_wrap ? '0 : idx_q + IW'(1);
      blink_cnt_d = blink_cnt_q + BLINK_LOG2'(1);
      if (blink_cnt_d == '0) begin
        blink_phase_d = ~blink_phase_q;
      end
    end
  end

  // Pin values for the digit under scan, from current counters and inputs
  always_comb begin
    nib          = disp.overlay_en ? overlay_w[{idx_q, 2'b00} +: 4]
                                   : disp.value[{idx_q, 2'b00} +: 4];
    dark         = disp.blank[idx_q] | (disp.blink_en[idx_q] & blink_phase_q);
    onehot       = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    an_d         = AN_OFF;
    seg_d        = SEG7_BLANK;
    seg_dp_d     = 1'b0;
    frame_tick_d = frame_wrap;
    if (!(int'(presc_q) < DEAD) && !dark) begin
      an_d     = (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
      seg_d    = nib_seg;
      seg_dp_d = disp.dp[idx_q];
    end
  end

  // Counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_q         <= SEG7_BLANK;
      seg_dp_q      <= 1'b0;
      an_q          <= AN_OFF;
      frame_tick_q  <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
      seg_dp_q      <= seg_dp_d;
      an_q          <= an_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign disp.seg        = seg_q;
  assign disp.seg_dp     = seg_dp_q;
  assign disp.an         = an_q;
  assign disp.scan_idx   = idx_q;
  assign disp.frame_tick = frame_tick_q;

endmodule
